imem_fetch_port: RTL
====================

// Module: imem_fetch_port
//
// PURPOSE
//   Parametrised, clocked instruction memory with a valid/ready fetch port,
//   a byte-wide program-load port and fault reporting. Replaces the
//   combinational 1 KiB byte array feeding IF.
//   Returns little-endian 32-bit words {b[a+3],b[a+2],b[a+1],b[a]}.
//   Sits between the PC/fetch stage and the IF/ID register.
//
// PARAMETERS
//   DEPTH_BYTES  1024          bytes of storage; must be a multiple of 4, >= 8
//   ADDR_W       32            width of fetch and load addresses
//   FAULT_INST   32'h00000013  word returned on a fault (addi x0,x0,0 = NOP)
//
// PORTS
//   clk          in   1       clock, rising edge
//   rst_n        in   1       asynchronous reset, active low
//   req_valid    in   1       fetch request valid
//   req_ready    out  1       fetch request can be accepted this cycle
//   req_addr     in   ADDR_W  byte address of the instruction
//   rsp_valid    out  1       response holds a word
//   rsp_ready    in   1       consumer takes the response this cycle
//   rsp_inst     out  32      fetched instruction word
//   rsp_addr     out  ADDR_W  address that produced rsp_inst
//   rsp_misalign out  1       req_addr[1:0] != 0
//   rsp_oob      out  1       req_addr > DEPTH_BYTES-4
//   ld_en        in   1       write one byte into the array
//   ld_addr      in   ADDR_W  byte address for the load
//   ld_data      in   8       byte to write
//   ld_err       out  1       sticky: a load targeted an address >= DEPTH_BYTES
//
// BEHAVIOUR
//   - Reset values: rsp_valid=0, rsp_inst=FAULT_INST, rsp_addr=0,
//     rsp_misalign=0, rsp_oob=0, ld_err=0.
//     The byte array is NOT reset and keeps its contents through rst_n.
//   - req_ready = !rsp_valid || rsp_ready. This is combinational and gives a
//     single-entry output register with no bubble when streaming.
//   - Handshake rules:
//     - A request is accepted when req_valid && req_ready at a rising edge.
//     - The response is registered and appears with rsp_valid=1 on the next
//       cycle, so latency is 1.
//     - rsp_valid falls when rsp_ready=1 and no new request is accepted in
//       the same cycle.
//     - While rsp_valid && !rsp_ready, all rsp_* outputs hold stable.
//   - Back-to-back: if the response is consumed and a new request is accepted
//     in the same cycle, rsp_valid stays 1 and rsp_* update. Throughput is
//     1 word per clock.
//   - Fault handling:
//     - If misaligned or out of range, set the matching flag(s), set
//       rsp_inst=FAULT_INST, and make no array read.
//     - Both flags may be set together.
//     - The out-of-range test uses the full ADDR_W compare, with no wrap at
//       DEPTH_BYTES.
//   - Load port:
//     - When ld_en=1 and ld_addr < DEPTH_BYTES, ld_data is written at the
//       rising edge.
//     - Any other ld_en=1 sets ld_err; it clears only on reset.
//     - Loads are independent of the fetch handshake and never stall it.
//   - Simultaneous load and fetch of the same word in one cycle returns the
//     pre-write bytes (read-before-write). The new byte is visible to the
//     next accepted fetch.
//   - Reset mid-operation: an in-flight response is dropped (rsp_valid=0
//     immediately). Requests held during reset are not accepted until the
//     first edge after rst_n deasserts.
//   - Internal state is just the valid/full bit. EMPTY->FULL on accept;
//     FULL->EMPTY on consume without accept; FULL->FULL on accept with
//     consume.
//
// TESTING
//   1. Load bytes 33,89,A9,00 at 0..3; fetch 0 -> next cycle rsp_valid=1,
//      rsp_inst=32'h00A98933, rsp_addr=0, no flags.
//   2. Load 93,87,E0,FC at 4..7, 37,35,AB,ED at 16..19; stream fetches
//      0,4,16 with rsp_ready=1 -> consecutive cycles give 00A98933,
//      FCE08793, EDAB3537; req_ready stays 1.
//   3. Fetch 4 with rsp_ready=0 for 3 cycles -> rsp_inst=FCE08793 held,
//      req_ready=0; raise rsp_ready -> consumed, req_ready=1.
//   4. Fetch 2 -> rsp_misalign=1, rsp_inst=00000013. Fetch 1024 -> rsp_oob=1.
//      Fetch 1022 -> both flags set.
//   5. Same cycle: load byte 0=FF and fetch 0 -> returns 00A98933. Next
//      fetch 0 -> 00A989FF. Load at 1024 -> ld_err=1, array unchanged.
//   6. Assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 at once. After
//      release, fetch 0 still returns the loaded word.

Source files
------------

// File: rtl/imem_fetch_port_if.sv
// imem_fetch_port_if: fetch request/response handshake between the PC stage and instruction memory.
interface imem_fetch_port_if #(parameter int ADDR_W = 32);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_inst;
   logic [ADDR_W-1:0] rsp_addr;
   logic              rsp_misalign;
   logic              rsp_oob;
   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_misalign, rsp_oob
   );
   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_misalign, rsp_oob
   );
endinterface

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: byte-loadable instruction memory with a 1-deep registered valid/ready fetch port.
module imem_fetch_port #(
   parameter int          DEPTH_BYTES = 1024,
   parameter int          ADDR_W      = 32,
   parameter logic [31:0] FAULT_INST  = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst_n,
   imem_fetch_port_if.slave  bus,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data,
   output logic              ld_err
);
   localparam int                IDX_W  = $clog2(DEPTH_BYTES);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_BYTES);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH_BYTES - 4);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t             state, state_nxt;
   logic [7:0]         mem [DEPTH_BYTES];
   logic               accept, ld_ok, misalign, oob;
   logic [IDX_W-3:0]   w;
   logic [31:0]        word;
   assign accept   = bus.req_valid && bus.req_ready;
   assign ld_ok    = ld_addr < DEPTH_A;
   assign misalign = bus.req_addr[1:0] != 2'd0;
   assign oob      = bus.req_addr > LAST_A;
   assign w        = bus.req_addr[IDX_W-1:2];
   assign word     = (misalign || oob) ? FAULT_INST
                   : {mem[{w, 2'd3}], mem[{w, 2'd2}], mem[{w, 2'd1}], mem[{w, 2'd0}]};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   always_comb
      state_nxt = accept ? FULL : (bus.rsp_ready ? EMPTY : state);
   always_comb begin
      bus.rsp_valid = state == FULL;
      bus.req_ready = state == EMPTY || bus.rsp_ready;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.rsp_inst     <= FAULT_INST;
         bus.rsp_addr     <= '0;
         bus.rsp_misalign <= 1'b0;
         bus.rsp_oob      <= 1'b0;
         ld_err           <= 1'b0;
      end else begin
         if (accept) begin
            bus.rsp_inst     <= word;
            bus.rsp_addr     <= bus.req_addr;
            bus.rsp_misalign <= misalign;
            bus.rsp_oob      <= oob;
         end
         if (ld_en && !ld_ok) ld_err <= 1'b1;
      end
   // array is deliberately unreset; the fetch read above sees pre-write bytes
   always_ff @(posedge clk)
      if (ld_en && ld_ok) mem[ld_addr[IDX_W-1:0]] <= ld_data;
endmodule
